// File: rtl/p2s_arbiter.sv
// -----------------------------------------------------------------------------
// p2s_arbiter
//
// Shares one p2s serializer among R parallel-word requesters. A winner is
// chosen in IDLE and holds the grant for up to BURST words. One IDLE bubble
// always separates consecutive grants.
//
// Handshake semantics (all interfaces): a word moves on a rising edge where
// valid and ready are both high. Ready may depend combinationally on valid.
// A source holding valid keeps its data stable until ready. A source may
// drop valid; for the owner that ends the grant early.
//
// Optional feature macro: P2S_ARB_FIXED_PRIO_EN
//   defined   : lowest-index valid requester always wins; rr pointer frozen
//   undefined : round-robin starting from the rr pointer (default)
//
// Ports:
//   clk        in   clock, rising edge
//   rstn       in   synchronous active-low reset
//   req_data   in   R*N  requester words, requester i at [i*N +: N]
//   req_valid  in   R    requester i has a word
//   req_ready  out  R    word of requester i accepted this cycle
//   par_data   out  N    word to p2s
//   par_valid  out  1    par_data valid to p2s
//   par_ready  in   1    p2s accepts par_data
//   grant_id   out  GW   current owner, 0 when idle
//   busy       out  1    grant held (FSM is in GRANT); doubles as state debug
// -----------------------------------------------------------------------------
module p2s_arbiter #(
  parameter int N     = 8,
  parameter int R     = 3,
  parameter int BURST = 4,
  localparam int GW   = (R > 1) ? $clog2(R) : 1
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [R*N-1:0]  req_data,
  input  logic [R-1:0]    req_valid,
  output logic [R-1:0]    req_ready,
  output logic [N-1:0]    par_data,
  output logic            par_valid,
  input  logic            par_ready,
  output logic [GW-1:0]   grant_id,
  output logic            busy
);

  localparam int BW = (BURST > 1) ? $clog2(BURST) : 1;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [GW-1:0]   grant_q, grant_d;
  logic [GW-1:0]   rr_q, rr_d;
  logic [BW-1:0]   beat_q, beat_d;

  logic [GW-1:0]   winner;
  logic            found;
  logic            owner_valid;
  logic            handshake;
  logic            last_beat;

  // ---------------------------------------------------------------------------
  // Winner selection. Offset k is the priority rank; requester j has rank k
  // when j == (start + k) mod R. The first valid requester in rank order wins.
  // ---------------------------------------------------------------------------
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int k = 0; k < R; k++) begin
      for (int j = 0; j < R; j++) begin
`ifdef P2S_ARB_FIXED_PRIO_EN
        if (!found && req_valid[j] && (j == k)) begin
`else
        if (!found && req_valid[j] && (j == ((int'(rr_q) + k) % R))) begin
`endif
          found  = 1'b1;
          winner = GW'(j);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Owner data path: zero-cycle pass-through of the owner in GRANT.
  // ---------------------------------------------------------------------------
  always_comb begin
    owner_valid = 1'b0;
    par_data    = '0;
    req_ready   = '0;
    if (state_q == GRANT) begin
      for (int j = 0; j < R; j++) begin
        if (grant_q == GW'(j)) begin
          owner_valid  = req_valid[j];
          par_data     = req_data[j*N +: N];
          req_ready[j] = par_ready & req_valid[j];
        end
      end
    end
    par_valid = owner_valid;
  end

  assign handshake = par_valid & par_ready;
  assign last_beat = (beat_q == BW'(BURST - 1));
  assign busy      = (state_q == GRANT);
  assign grant_id  = grant_q;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    beat_d  = beat_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = GRANT;
          grant_d = winner;
          beat_d  = '0;
        end
      end
      GRANT: begin
        // Release either early (owner withdrew) or after the last beat.
        if (!owner_valid || (handshake && last_beat)) begin
          state_d = IDLE;
          grant_d = '0;
          beat_d  = '0;
`ifndef P2S_ARB_FIXED_PRIO_EN
          rr_d    = (grant_q == GW'(R - 1)) ? '0 : grant_q + GW'(1);
`endif
        end else if (handshake) begin
          beat_d = beat_q + BW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        beat_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      grant_q <= '0;
      rr_q    <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      beat_q  <= beat_d;
    end
  end

endmodule

// File: tb/tb_p2s_arbiter.sv
// -----------------------------------------------------------------------------
// tb_p2s_arbiter
//
// Random requester traffic against a transaction-level model of the arbiter.
// Inputs change on the falling edge, outputs are compared 1 time unit later.
// Phases: all requesters streaming with par_ready high, fully random traffic
// with backpressure, early withdrawal and random resets, then requesters 0
// and 2 only (exposes round-robin vs fixed-priority behaviour).
// -----------------------------------------------------------------------------
module tb_p2s_arbiter;

  localparam int N     = 8;
  localparam int R     = 3;
  localparam int BURST = 4;
  localparam int GW    = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rstn;
  logic [R*N-1:0]  req_data;
  logic [R-1:0]    req_valid;
  logic [R-1:0]    req_ready;
  logic [N-1:0]    par_data;
  logic            par_valid;
  logic            par_ready;
  logic [GW-1:0]   grant_id;
  logic            busy;

  p2s_arbiter #(.N(N), .R(R), .BURST(BURST)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .req_data  (req_data),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .par_data  (par_data),
    .par_valid (par_valid),
    .par_ready (par_ready),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  // ---------------- scoreboard ----------------
  int check_cnt = 0;
  int pass_cnt  = 0;
  logic [N-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // ---------------- requester sources ----------------
  logic [N-1:0] word [R];
  bit           valid[R];
  int           mode;

  // ---------------- reference model ----------------
  bit m_busy;
  int m_owner;
  int m_words;   // words moved in the current grant
  int m_ptr;
  int grants[R];

  function automatic int pick(input bit [R-1:0] v, input int ptr);
    for (int k = 0; k < R; k++) begin
`ifdef P2S_ARB_FIXED_PRIO_EN
      if (v[k]) return k;
`else
      if (v[(ptr + k) % R]) return (ptr + k) % R;
`endif
    end
    return 0;
  endfunction

  task automatic model_release();
`ifndef P2S_ARB_FIXED_PRIO_EN
    m_ptr = (m_owner + 1) % R;
`endif
    m_busy  = 0;
    m_owner = 0;
    m_words = 0;
  endtask

  // ---------------- driver ----------------
  task automatic drive_inputs();
    int vp, rp;
    vp = (mode == 1) ? 60 : 100;
    rp = (mode == 1) ? 55 : 100;
    for (int i = 0; i < R; i++) begin
      if (!valid[i]) begin
        if ((mode != 2 || i != 1) && $urandom_range(0, 99) < vp) begin
          valid[i] = 1;
          word[i]  = N'($urandom);
        end
      end
      req_valid[i]        = valid[i];
      req_data[i*N +: N]  = word[i];
    end
    par_ready = ($urandom_range(0, 99) < rp);
    rstn      = !(mode == 1 && $urandom_range(0, 99) < 2);
  endtask

  // ---------------- one cycle: drive, compare, advance model ----------------
  task automatic step();
    bit [R-1:0] vvec;
    bit         hs;
    int         own;
    logic [R-1:0] e_rr;
    @(negedge clk);
    drive_inputs();
    #1;
    for (int i = 0; i < R; i++) vvec[i] = valid[i];
    own  = m_owner;
    hs   = m_busy && valid[own] && par_ready;
    e_rr = hs ? R'(1 << own) : '0;

    check("busy",      32'(busy),      32'(m_busy));
    check("grant_id",  32'(grant_id),  m_busy ? own : 0);
    check("par_valid", 32'(par_valid), m_busy ? 32'(valid[own]) : 0);
    check("par_data",  32'(par_data),  m_busy ? 32'(word[own]) : 0);
    check("req_ready", 32'(req_ready), 32'(e_rr));

    if (hs) exp_q.push_back(word[own]);
    if (par_valid === 1'b1 && par_ready) begin
      if (exp_q.size() == 0) check("sb_unexpected_word", 32'(par_data), 32'hFFFF_FFFF);
      else check("sb_word", 32'(par_data), 32'(exp_q.pop_front()));
    end

    // state advance at the coming rising edge
    if (!rstn) begin
      m_busy = 0; m_owner = 0; m_words = 0; m_ptr = 0;
    end else if (!m_busy) begin
      if (vvec != 0) begin
        m_owner = pick(vvec, m_ptr);
        m_busy  = 1;
        m_words = 0;
        if (mode == 2) grants[m_owner]++;
      end
    end else if (!valid[own]) begin
      model_release();
    end else if (hs) begin
      m_words++;
      if (m_words == BURST) model_release();
    end

    if (hs) valid[own] = 0;
  endtask

  // ---------------- main ----------------
  initial begin
    rstn      = 1'b0;
    par_ready = 1'b0;
    req_valid = '0;
    req_data  = '0;
    for (int i = 0; i < R; i++) begin
      valid[i] = 0;
      word[i]  = '0;
      grants[i] = 0;
    end
    m_busy = 0; m_owner = 0; m_words = 0; m_ptr = 0;
    mode = 0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy",      32'(busy),      0);
    check("reset_par_valid", 32'(par_valid), 0);
    check("reset_grant_id",  32'(grant_id),  0);
    check("reset_req_ready", 32'(req_ready), 0);

    mode = 0;
    repeat (300) step();
    mode = 1;
    repeat (1500) step();
    // clean restart before the two-requester phase
    @(negedge clk);
    rstn = 1'b0;
    for (int i = 0; i < R; i++) begin
      valid[i] = 0;
      req_valid[i] = 1'b0;
    end
    m_busy = 0; m_owner = 0; m_words = 0; m_ptr = 0;
    exp_q.delete();
    mode = 2;
    repeat (300) step();

`ifdef P2S_ARB_FIXED_PRIO_EN
    check("fixed_prio_r2_grants", 32'(grants[2]), 0);
`else
    check("rr_r2_grants_balance", 32'(grants[2] >= grants[0] - 1), 1);
`endif
    check("sb_leftover", 32'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
